// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: peripheral address map,
// responder FSM states and timer control/register encodings.
package mio_pkg;

  // Peripheral word addresses (bits [1:0] of the CPU address are ignored).
  localparam logic [31:0] ADDR_LED   = 32'hF000_0000;
  localparam logic [31:0] ADDR_SW    = 32'hF000_0004;
  localparam logic [31:0] ADDR_TCNT  = 32'hF000_0010;
  localparam logic [31:0] ADDR_TCMP  = 32'hF000_0014;
  localparam logic [31:0] ADDR_TCTL  = 32'hF000_0018;
  localparam logic [31:0] ADDR_TSTAT = 32'hF000_001C;

  // Addr_in[31:28] value that selects the word RAM.
  localparam logic [3:0] RAM_REGION = 4'h0;

  // Responder FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mio_state_e;

  // TCTL bit positions.
  localparam int unsigned TCTL_EN   = 0;
  localparam int unsigned TCTL_IE   = 1;
  localparam int unsigned TCTL_AUTO = 2;

  // Timer register select, equal to address bits [3:2] inside the timer window.
  typedef enum logic [1:0] {
    TREG_CNT  = 2'd0,
    TREG_CMP  = 2'd1,
    TREG_CTL  = 2'd2,
    TREG_STAT = 2'd3
  } treg_e;

endpackage

// File: rtl/mio_timer.sv
// Interval timer: free-running TCNT compared against TCMP, with pending flag
// and a registered, level-sensitive interrupt output.
module mio_timer
  import mio_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  treg_e       sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        int_o
);

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [2:0]  tctl_q, tctl_d;
  logic        pend_q, pend_d;
  logic        int_q;

  logic wr_cnt, wr_cmp, wr_ctl, wr_stat;
  logic match;

  assign wr_cnt  = we_i && (sel_i == TREG_CNT);
  assign wr_cmp  = we_i && (sel_i == TREG_CMP);
  assign wr_ctl  = we_i && (sel_i == TREG_CTL);
  assign wr_stat = we_i && (sel_i == TREG_STAT);

  // A CPU write to TCNT suppresses the compare on that edge.
  assign match = tctl_q[TCTL_EN] && (tcnt_q == tcmp_q) && !wr_cnt;

  // Next-state for counter, compare, control and pending flag.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    tctl_d = tctl_q;
    pend_d = pend_q;

    if (wr_cnt) begin
      tcnt_d = wdata_i;
    end else if (match) begin
      if (tctl_q[TCTL_AUTO]) tcnt_d = '0;
    end else if (tctl_q[TCTL_EN]) begin
      tcnt_d = tcnt_q + 32'd1;
    end

    if (wr_cmp) tcmp_d = wdata_i;

    // One-shot mode stops the timer on match; a CPU write to TCTL wins.
    if (match && !tctl_q[TCTL_AUTO]) tctl_d[TCTL_EN] = 1'b0;
    if (wr_ctl) tctl_d = wdata_i[2:0];

    // Set has priority over write-1-to-clear.
    if (wr_stat && wdata_i[0]) pend_d = 1'b0;
    if (match) pend_d = 1'b1;
  end

  // Timer state registers; INT lags PEND by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= '0;
      tcmp_q <= '0;
      tctl_q <= '0;
      pend_q <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      tctl_q <= tctl_d;
      pend_q <= pend_d;
      int_q  <= pend_q & tctl_q[TCTL_IE];
    end
  end

  // Register read mux.
  always_comb begin
    rdata_o = '0;
    unique case (sel_i)
      TREG_CNT:  rdata_o = tcnt_q;
      TREG_CMP:  rdata_o = tcmp_q;
      TREG_CTL:  rdata_o[2:0] = tctl_q;
      TREG_STAT: rdata_o[0] = pend_q;
      default:   rdata_o = '0;
    endcase
  end

  assign int_o = int_q;

endmodule

// File: rtl/mio_responder.sv
// MIO bus slave: one access at a time, WAIT_CYCLES wait states, one-cycle
// MIO_ready pulse. Hosts word RAM, LED/switch GPIO and the interval timer.
// Optional build macro MIO_BYTE_EN_EN adds a byte-enable input `be`.
module mio_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned GPIO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
`ifdef MIO_BYTE_EN_EN
  input  logic [3:0]        be,
`endif
  output logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic              INT,
  input  logic [GPIO_W-1:0] sw_in,
  output logic [GPIO_W-1:0] led_out
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mio_state_e state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [3:0]  be_q;

  logic [3:0]  be_in;
  logic        capture;
  logic        exec;

  logic [31:2] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:0] acc_word;

  logic        sel_ram, sel_led, sel_sw, sel_tmr;
  treg_e       tmr_sel;
  logic        periph_we;

  logic [31:0]       ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_rdata;

  logic [GPIO_W-1:0] led_q;
  logic [31:0]       data_out_q;
  logic [31:0]       tmr_rdata;
  logic [31:0]       rdata;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Addr_in[1:0];

`ifdef MIO_BYTE_EN_EN
  assign be_in = be;
`else
  assign be_in = 4'hF;
`endif

  assign capture = (state_q == IDLE) && CPU_MIO;
  // The access takes effect on the edge that enters RESP.
  assign exec    = (state_d == RESP);

  // Responder FSM next state and wait-state counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (CPU_MIO) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and captured request; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (capture) begin
        addr_q  <= Addr_in[31:2];
        wdata_q <= Data_in;
        we_q    <= mem_w;
        be_q    <= be_in;
      end
    end
  end

  // With no wait states the access executes on the capture edge itself,
  // so the live bus values are used directly.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr  = Addr_in[31:2];
      acc_wdata = Data_in;
      acc_we    = mem_w;
      acc_be    = be_in;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_we    = we_q;
      acc_be    = be_q;
    end
  end

  // Address decode.
  always_comb begin
    acc_word  = {acc_addr, 2'b00};
    sel_ram   = (acc_addr[31:28] == RAM_REGION);
    sel_led   = (acc_word == ADDR_LED);
    sel_sw    = (acc_word == ADDR_SW);
    sel_tmr   = (acc_word[31:4] == ADDR_TCNT[31:4]);
    tmr_sel   = treg_e'(acc_word[3:2]);
    periph_we = exec && acc_we && (acc_be == 4'hF);
  end

  assign ram_idx   = acc_addr[RAM_AW+1:2];
  assign ram_rdata = ram_q[ram_idx];

  // Word RAM write port with per-lane enables.
  always_ff @(posedge clk) begin
    // NOTE: RAM contents are deliberately not reset; a reset branch would
    // turn the array into flops and block RAM inference.
    if (exec && acc_we && sel_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) ram_q[ram_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Read data mux; unmapped addresses read zero.
  always_comb begin
    rdata = '0;
    if (sel_ram)      rdata = ram_rdata;
    else if (sel_led) rdata[GPIO_W-1:0] = led_q;
    else if (sel_sw)  rdata[GPIO_W-1:0] = sw_in;
    else if (sel_tmr) rdata = tmr_rdata;
  end

  // LED register and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q      <= '0;
      data_out_q <= '0;
    end else begin
      if (periph_we && sel_led) led_q <= acc_wdata[GPIO_W-1:0];
      if (exec && !acc_we)      data_out_q <= rdata;
    end
  end

  mio_timer u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (periph_we && sel_tmr),
    .sel_i   (tmr_sel),
    .wdata_i (acc_wdata),
    .rdata_o (tmr_rdata),
    .int_o   (INT)
  );

  assign Data_out  = data_out_q;
  assign MIO_ready = (state_q == RESP);
  assign led_out   = led_q;

endmodule

// File: doc/mio_responder.md
Name: mio_responder

Overview:
- Slave end of the CPU memory/IO (MIO) bus.
- Accepts one load/store at a time from the pipelined CPU and performs it after a programmable number of wait states.
- Returns read data with a one-cycle MIO_ready pulse.
- Hosts a word RAM, a GPIO block and an interval timer. The timer drives the CPU's external INT line.

Parameters:
- RAM_AW, 10, RAM word-address width; depth is 2^RAM_AW words.
- WAIT_CYCLES, 1, extra wait states before response, range 0..15.
- GPIO_W, 16, width of led_out and sw_in.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- CPU_MIO  in  1  access request; held by the CPU until MIO_ready.
- mem_w  in  1  1 = write, 0 = read; sampled with CPU_MIO.
- Addr_in  in  32  byte address; bits [1:0] are ignored.
- Data_in  in  32  write data from the CPU.
- Data_out  out  32  read data to the CPU; valid while MIO_ready=1.
- MIO_ready  out  1  one-cycle completion pulse.
- INT  out  1  registered interrupt request, level-sensitive.
- sw_in  in  GPIO_W  switch inputs, used directly with no synchroniser.
- led_out  out  GPIO_W  LED register.

Behaviour:
- Reset values: Data_out=0, MIO_ready=0, INT=0, led_out=0. All timer registers are 0. FSM is in IDLE. RAM contents are not reset.

Address map (Addr_in[31:28]=0 selects RAM, word index Addr_in[RAM_AW+1:2]):
- 0xF000_0000  LED, read/write; reads return zero-extended led_out.
- 0xF000_0004  SW, read-only.
- 0xF000_0010  TCNT, read/write.
- 0xF000_0014  TCMP, read/write.
- 0xF000_0018  TCTL, read/write. bit0=EN, bit1=IE, bit2=AUTO; other bits read 0.
- 0xF000_001C  TSTAT, bit0=PEND. Writing 1 clears PEND; writing 0 has no effect.
- Any other address: reads return 0, writes are dropped. MIO_ready is still issued.

FSM states IDLE, WAIT, RESP:
- IDLE: when CPU_MIO=1, capture addr, wdata and mem_w.
  - If WAIT_CYCLES>0, load wcnt=WAIT_CYCLES-1 and go to WAIT.
  - Otherwise go to RESP.
- WAIT: decrement wcnt; when wcnt=0, go to RESP.
- On the edge entering RESP, the access executes: write commits, or read data is registered into Data_out.
- RESP: MIO_ready=1 for exactly this cycle, then return to IDLE.
- Latency from the capture edge to MIO_ready high is WAIT_CYCLES+1 cycles.
- CPU_MIO is not sampled in WAIT or RESP. Requests that are back-to-back are accepted in IDLE on the cycle after RESP.
- Data_out holds its last value outside RESP.
- Reset asserted mid-access: FSM returns to IDLE and the access is abandoned with no write.

Timer:
- When EN=1, TCNT increments every cycle, wrapping at 2^32.
- When TCNT==TCMP and EN=1, PEND is set.
  - If AUTO=1, TCNT loads 0 on that edge.
  - If AUTO=0, TCNT holds and EN clears.
- INT is registered: INT <= PEND & IE, so it lags PEND by one cycle.
- CPU write to TCNT on the same edge as a match: the write value wins and no match is taken that cycle.
- Set and clear of PEND on the same edge: set wins.

Optional Feature:
- Macro: MIO_BYTE_EN_EN.
- With the macro defined:
  - Adds an input port be (4 bits).
  - RAM writes update only the byte lanes whose be bit is 1.
  - Peripheral writes require be=4'hF and are dropped otherwise.
  - be is captured with CPU_MIO.
- Without the macro: no be port, and every write is a full 32-bit word.

Decomposition:
- Package mio_pkg holds:
  - the address constants (LED, SW, TCNT, TCMP, TCTL, TSTAT, RAM region nibble);
  - the FSM state enum (IDLE, WAIT, RESP);
  - the TCTL bit indices.
- Sub-module mio_timer contains TCNT, TCMP, TCTL, PEND and the INT register. It has a write strobe, an address select and wdata in, and register read data out.
- Address decode, FSM, RAM and GPIO stay in the top module.

Test Plan:
- WAIT_CYCLES=1, write 0xDEADBEEF to 0x0000_0010, then read it back -> each MIO_ready comes 2 cycles after capture; read Data_out=0xDEADBEEF.
- Write 0x00A5 to LED, read SW with sw_in=0x1234 -> led_out=0x00A5; Data_out=0x0000_1234.
- TCMP=5, TCTL=0x7 -> PEND sets when TCNT=5 and TCNT reloads 0; INT=1 one cycle later; write 1 to TSTAT -> INT=0 the cycle after PEND clears.
- TCTL=0x3 (AUTO=0), TCMP=3 -> TCNT holds at 3 and EN reads 0 after the match.
- Read 0x8000_0000 -> Data_out=0 with MIO_ready; write 0xFFFFFFFF to 0x8000_0000, then read RAM word 0 -> RAM unchanged.
- Drop reset during WAIT of a RAM write -> MIO_ready never pulses, RAM word unchanged, Data_out=0; MIO_BYTE_EN_EN build with be=4'b0010, wdata 0x0000AB00 over 0x11223344 -> RAM=0x1122AB44.
